mmc1_gen: RTL and testbench



---
 rtl/mmc1_gen_pkg.sv | 28 ++
 rtl/mmc1_gen_serial.sv | 72 +++++++
 rtl/mmc1_gen.sv | 132 +++++++++++++
 tb/tb_mmc1_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmc1_gen_pkg.sv
// mmc1_gen_pkg: shared constants for the MMC1-class mapper.
//   - register index values carried by the serial loader's load strobe
//   - nametable mirroring encoding held in control[1:0]
//   - control reset value and PRG banking mode encodings held in control[3:2]
package mmc1_gen_pkg;

    // Register select, taken from {CPU_A14, CPU_A13} on the fifth serial write
    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_CHR0 = 2'd1;
    localparam logic [1:0] REG_CHR1 = 2'd2;
    localparam logic [1:0] REG_PRG  = 2'd3;

    typedef enum logic [1:0] {
        MirrOneA = 2'd0,
        MirrOneB = 2'd1,
        MirrVert = 2'd2,
        MirrHorz = 2'd3
    } mirr_e;

    // PRG mode 3 (fixed last bank at $C000), everything else cleared
    localparam logic [4:0] CTRL_RST = 5'h0C;

    localparam logic [1:0] PRG_MODE_32K_0  = 2'd0;
    localparam logic [1:0] PRG_MODE_32K_1  = 2'd1;
    localparam logic [1:0] PRG_MODE_FIX_LO = 2'd2;
    localparam logic [1:0] PRG_MODE_FIX_HI = 2'd3;

endpackage

// File: rtl/mmc1_gen_serial.sv
// mmc1_gen_serial: 5-bit serial loader of the MMC1 mapper.
//   clk_i, rst_i       clock (M2) and synchronous active-high reset
//   wr_i               write cycle to $8000-$FFFF on this edge
//   d7_i, d0_i         reset bit and serial data bit
//   sel_i              {CPU_A14, CPU_A13}, target register of a completed load
//   load_o             one-cycle strobe: data_o goes into register idx_o at this edge
//   reset_wr_o         reset write (D7=1) at this edge
//   idx_o, data_o      target register and the 5-bit value to load
module mmc1_gen_serial
    import mmc1_gen_pkg::*;
#(
    parameter int WRITE_FILTER = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_i,
    input  logic       d7_i,
    input  logic       d0_i,
    input  logic [1:0] sel_i,
    output logic       load_o,
    output logic       reset_wr_o,
    output logic [1:0] idx_o,
    output logic [4:0] data_o
);

    logic [4:0] shift_q, shift_d;
    logic [2:0] count_q, count_d;
    logic       filt_q,  filt_d;
    logic       accept;

    assign data_o = {d0_i, shift_q[4:1]};
    assign idx_o  = sel_i;

    // A serial write directly after any write cycle (e.g. the dummy write of
    // a CPU read-modify-write) is dropped when filtering is enabled.
    assign accept = wr_i && !d7_i && !((WRITE_FILTER != 0) && filt_q);

    always_comb begin
        shift_d    = shift_q;
        count_d    = count_q;
        filt_d     = wr_i;
        load_o     = 1'b0;
        reset_wr_o = 1'b0;
        if (wr_i && d7_i) begin
            reset_wr_o = 1'b1;
            shift_d    = 5'h00;
            count_d    = 3'd0;
        end else if (accept) begin
            if (count_q == 3'd4) begin
                load_o  = 1'b1;
                shift_d = 5'h00;
                count_d = 3'd0;
            end else begin
                shift_d = data_o;
                count_d = count_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= 5'h00;
            count_q <= 3'd0;
            filt_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
            filt_q  <= filt_d;
        end
    end

endmodule

// File: rtl/mmc1_gen.sv
// mmc1_gen: MMC1-class NES mapper with configurable PRG/CHR width.
//   M2, RST                    clock (one edge per CPU cycle), sync active-high reset
//   nROMSEL, CPU_RnW           CPU ROM select (low active) and read/write
//   CPU_A14, CPU_A13           register / window select
//   CPU_D7, CPU_D0             reset bit / serial data bit
//   PPU_A12..PPU_A10           PPU address bits for CHR banking and mirroring
//   PRG_A, PRG_nCE, SRAM_CE    PRG ROM upper address, ROM enable, PRG-RAM enable
//   CHR_A, CIRAM_A10           CHR upper address, nametable select
module mmc1_gen
    import mmc1_gen_pkg::*;
#(
    parameter int PRG_AW       = 18,
    parameter int CHR_AW       = 17,
    parameter int WRITE_FILTER = 1,
    parameter int RAM_DIS_EN   = 1
) (
    input  logic              M2,
    input  logic              RST,
    input  logic              nROMSEL,
    input  logic              CPU_RnW,
    input  logic              CPU_A14,
    input  logic              CPU_A13,
    input  logic              CPU_D7,
    input  logic              CPU_D0,
    input  logic              PPU_A12,
    input  logic              PPU_A11,
    input  logic              PPU_A10,
    output logic [PRG_AW-15:0] PRG_A,
    output logic              PRG_nCE,
    output logic              SRAM_CE,
    output logic [CHR_AW-13:0] CHR_A,
    output logic              CIRAM_A10
);

    logic [4:0] ctrl_q, ctrl_d;
    logic [4:0] chr0_q, chr0_d;
    logic [4:0] chr1_q, chr1_d;
    logic [4:0] prg_q,  prg_d;

    logic       load;
    logic       reset_wr;
    logic [1:0] idx;
    logic [4:0] data;

    mmc1_gen_serial #(
        .WRITE_FILTER (WRITE_FILTER)
    ) u_serial (
        .clk_i      (M2),
        .rst_i      (RST),
        .wr_i       (!nROMSEL && !CPU_RnW),
        .d7_i       (CPU_D7),
        .d0_i       (CPU_D0),
        .sel_i      ({CPU_A14, CPU_A13}),
        .load_o     (load),
        .reset_wr_o (reset_wr),
        .idx_o      (idx),
        .data_o     (data)
    );

    always_comb begin
        ctrl_d = ctrl_q;
        chr0_d = chr0_q;
        chr1_d = chr1_q;
        prg_d  = prg_q;
        if (reset_wr) begin
            ctrl_d[3:2] = 2'b11;
        end
        if (load) begin
            unique case (idx)
                REG_CTRL: ctrl_d = data;
                REG_CHR0: chr0_d = data;
                REG_CHR1: chr1_d = data;
                REG_PRG:  prg_d  = data;
            endcase
        end
    end

    always_ff @(posedge M2) begin
        if (RST) begin
            ctrl_q <= CTRL_RST;
            chr0_q <= 5'h00;
            chr1_q <= 5'h00;
            prg_q  <= 5'h00;
        end else begin
            ctrl_q <= ctrl_d;
            chr0_q <= chr0_d;
            chr1_q <= chr1_d;
            prg_q  <= prg_d;
        end
    end

    // PRG banking: 16K bank number in the low four bits, outer 256K select on top
    logic [3:0] prg_lo;
    logic       prg_outer;
    logic [4:0] prg_full;
    logic [4:0] chr_full;

    always_comb begin
        prg_lo = 4'h0;
        case (ctrl_q[3:2])
            PRG_MODE_FIX_LO: prg_lo = CPU_A14 ? prg_q[3:0] : 4'h0;
            PRG_MODE_FIX_HI: prg_lo = CPU_A14 ? 4'hF : prg_q[3:0];
            default:         prg_lo = {prg_q[3:1], CPU_A14};
        endcase
    end

    // SUROM-style outer bank follows whichever CHR register is currently selected
    assign prg_outer = (ctrl_q[4] && PPU_A12) ? chr1_q[4] : chr0_q[4];
    assign prg_full  = {prg_outer, prg_lo};

    assign chr_full = ctrl_q[4] ? (PPU_A12 ? chr1_q : chr0_q) : {chr0_q[4:1], PPU_A12};

    always_comb begin
        CIRAM_A10 = 1'b0;
        unique case (mirr_e'(ctrl_q[1:0]))
            MirrOneA: CIRAM_A10 = 1'b0;
            MirrOneB: CIRAM_A10 = 1'b1;
            MirrVert: CIRAM_A10 = PPU_A10;
            MirrHorz: CIRAM_A10 = PPU_A11;
        endcase
    end

    // Upper bits beyond the configured widths are intentionally dropped
    logic unused_bits;
    assign unused_bits = ^{prg_full, chr_full};

    assign PRG_A   = prg_full[PRG_AW-15:0];
    assign CHR_A   = chr_full[CHR_AW-13:0];
    assign PRG_nCE = nROMSEL | ~CPU_RnW;
    assign SRAM_CE = nROMSEL & CPU_A14 & CPU_A13 & ~((RAM_DIS_EN != 0) & prg_q[4]);

endmodule

// File: tb/tb_mmc1_gen.sv
// tb_mmc1_gen: directed bench for mmc1_gen. Three instances share one CPU/PPU bus:
//   dut    default widths, write filter on, RAM disable on
//   dut_nf same but write filter off
//   dut19  PRG_AW=19 (outer 256K bank)
module tb_mmc1_gen;

    logic m2 = 1'b0;
    logic rst = 1'b1;
    logic nromsel = 1'b1;
    logic rnw = 1'b1;
    logic a14 = 1'b0;
    logic a13 = 1'b0;
    logic d7 = 1'b0;
    logic d0 = 1'b0;
    logic ppu12 = 1'b0;
    logic ppu11 = 1'b0;
    logic ppu10 = 1'b0;

    logic [3:0] prg_a, prg_a_nf;
    logic [4:0] prg_a19;
    logic [4:0] chr_a, chr_a_nf, chr_a19;
    logic       prg_nce, prg_nce_nf, prg_nce19;
    logic       sram_ce, sram_ce_nf, sram_ce19;
    logic       ciram, ciram_nf, ciram19;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 m2 = ~m2;

    mmc1_gen #(.PRG_AW(18), .CHR_AW(17), .WRITE_FILTER(1), .RAM_DIS_EN(1)) dut (
        .M2(m2), .RST(rst), .nROMSEL(nromsel), .CPU_RnW(rnw), .CPU_A14(a14), .CPU_A13(a13),
        .CPU_D7(d7), .CPU_D0(d0), .PPU_A12(ppu12), .PPU_A11(ppu11), .PPU_A10(ppu10),
        .PRG_A(prg_a), .PRG_nCE(prg_nce), .SRAM_CE(sram_ce), .CHR_A(chr_a),
        .CIRAM_A10(ciram)
    );

    mmc1_gen #(.PRG_AW(18), .CHR_AW(17), .WRITE_FILTER(0), .RAM_DIS_EN(1)) dut_nf (
        .M2(m2), .RST(rst), .nROMSEL(nromsel), .CPU_RnW(rnw), .CPU_A14(a14), .CPU_A13(a13),
        .CPU_D7(d7), .CPU_D0(d0), .PPU_A12(ppu12), .PPU_A11(ppu11), .PPU_A10(ppu10),
        .PRG_A(prg_a_nf), .PRG_nCE(prg_nce_nf), .SRAM_CE(sram_ce_nf), .CHR_A(chr_a_nf),
        .CIRAM_A10(ciram_nf)
    );

    mmc1_gen #(.PRG_AW(19), .CHR_AW(17), .WRITE_FILTER(1), .RAM_DIS_EN(1)) dut19 (
        .M2(m2), .RST(rst), .nROMSEL(nromsel), .CPU_RnW(rnw), .CPU_A14(a14), .CPU_A13(a13),
        .CPU_D7(d7), .CPU_D0(d0), .PPU_A12(ppu12), .PPU_A11(ppu11), .PPU_A10(ppu10),
        .PRG_A(prg_a19), .PRG_nCE(prg_nce19), .SRAM_CE(sram_ce19), .CHR_A(chr_a19),
        .CIRAM_A10(ciram19)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_cycle();
        nromsel = 1'b1;
        rnw     = 1'b1;
        d7      = 1'b0;
        @(posedge m2);
        #1;
    endtask

    task automatic write_cyc(input logic sa14, input logic sa13, input logic sd7,
                             input logic sd0);
        nromsel = 1'b0;
        rnw     = 1'b0;
        a14     = sa14;
        a13     = sa13;
        d7      = sd7;
        d0      = sd0;
        @(posedge m2);
        #1;
        nromsel = 1'b1;
        rnw     = 1'b1;
        d7      = 1'b0;
    endtask

    // Five spaced serial writes, LSB first
    task automatic write_reg(input logic [1:0] sel, input logic [4:0] val);
        for (int i = 0; i < 5; i++) begin
            write_cyc(sel[1], sel[0], 1'b0, val[i]);
            idle_cycle();
        end
    endtask

    // Present a CPU read at the given window, settle, outputs then valid
    task automatic cpu_read(input logic sa14, input logic sa13);
        nromsel = 1'b0;
        rnw     = 1'b1;
        a14     = sa14;
        a13     = sa13;
        #1;
    endtask

    task automatic do_reset();
        nromsel = 1'b1;
        rnw     = 1'b1;
        rst     = 1'b1;
        repeat (2) @(posedge m2);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // Reset state
        check("rst_ctrl", 32'(dut.ctrl_q), 32'h0C);
        cpu_read(1'b0, 1'b0);
        check("rst_prg_8000", 32'(prg_a), 32'h0);
        check("rst_prg_nce", 32'(prg_nce), 32'h0);
        cpu_read(1'b1, 1'b0);
        check("rst_prg_c000", 32'(prg_a), 32'hF);
        check("rst_ciram", 32'(ciram), 32'h0);
        ppu12 = 1'b1;
        #1;
        check("rst_chr_a", 32'(chr_a), 32'h01);
        nromsel = 1'b1;
        a14 = 1'b1;
        a13 = 1'b1;
        #1;
        check("rst_sram_ce", 32'(sram_ce), 32'h1);

        // PRG = 5, mode 3
        write_reg(2'd3, 5'h05);
        cpu_read(1'b0, 1'b0);
        check("m3_prg_8000", 32'(prg_a), 32'h5);
        cpu_read(1'b1, 1'b0);
        check("m3_prg_c000", 32'(prg_a), 32'hF);

        // CHR 4K mode, 32K PRG mode
        write_reg(2'd0, 5'h10);
        write_reg(2'd1, 5'h03);
        write_reg(2'd2, 5'h07);
        ppu12 = 1'b0;
        #1;
        check("chr4k_lo", 32'(chr_a), 32'h03);
        ppu12 = 1'b1;
        #1;
        check("chr4k_hi", 32'(chr_a), 32'h07);
        cpu_read(1'b0, 1'b0);
        check("m0_prg_8000", 32'(prg_a), 32'h4);
        cpu_read(1'b1, 1'b0);
        check("m0_prg_c000", 32'(prg_a), 32'h5);

        // CHR 8K mode
        write_reg(2'd0, 5'h00);
        ppu12 = 1'b1;
        #1;
        check("chr8k_hi", 32'(chr_a), 32'h03);
        ppu12 = 1'b0;
        #1;
        check("chr8k_lo", 32'(chr_a), 32'h02);

        // Mode 2: $8000 fixed to bank 0
        write_reg(2'd0, 5'h08);
        cpu_read(1'b0, 1'b0);
        check("m2_prg_8000", 32'(prg_a), 32'h0);
        cpu_read(1'b1, 1'b0);
        check("m2_prg_c000", 32'(prg_a), 32'h5);

        // Mirroring
        write_reg(2'd0, 5'h01);
        check("mirr_one_b", 32'(ciram), 32'h1);
        write_reg(2'd0, 5'h02);
        ppu10 = 1'b1;
        ppu11 = 1'b0;
        #1;
        check("mirr_vert_1", 32'(ciram), 32'h1);
        ppu10 = 1'b0;
        #1;
        check("mirr_vert_0", 32'(ciram), 32'h0);
        write_reg(2'd0, 5'h03);
        ppu11 = 1'b1;
        #1;
        check("mirr_horz", 32'(ciram), 32'h1);
        ppu11 = 1'b0;

        // Back-to-back (RMW) writes
        do_reset();
        write_cyc(1'b0, 1'b0, 1'b0, 1'b1);
        write_cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("rmw_cnt_filt", 32'(dut.u_serial.count_q), 32'd1);
        check("rmw_cnt_nofilt", 32'(dut_nf.u_serial.count_q), 32'd2);
        idle_cycle();
        write_cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("rmw_after_idle", 32'(dut.u_serial.count_q), 32'd2);
        idle_cycle();

        // Reset write mid-sequence
        do_reset();
        write_reg(2'd0, 5'h01);
        for (int i = 0; i < 3; i++) begin
            write_cyc(1'b1, 1'b1, 1'b0, 1'b1);
            idle_cycle();
        end
        write_cyc(1'b1, 1'b1, 1'b1, 1'b0);
        check("d7_count", 32'(dut.u_serial.count_q), 32'd0);
        check("d7_ctrl", 32'(dut.ctrl_q), 32'h0D);
        check("d7_ciram", 32'(ciram), 32'h1);
        idle_cycle();
        write_reg(2'd3, 5'h0A);
        cpu_read(1'b0, 1'b0);
        check("d7_reload_8000", 32'(prg_a), 32'hA);

        // Outer 256K bank on PRG_AW=19
        write_reg(2'd1, 5'h10);
        cpu_read(1'b0, 1'b0);
        check("aw19_8000", 32'(prg_a19), 32'h1A);
        cpu_read(1'b1, 1'b0);
        check("aw19_c000", 32'(prg_a19), 32'h1F);
        check("aw18_c000", 32'(prg_a), 32'hF);

        // PRG-RAM disable
        write_reg(2'd3, 5'h10);
        nromsel = 1'b1;
        a14 = 1'b1;
        a13 = 1'b1;
        #1;
        check("sram_disabled", 32'(sram_ce), 32'h0);
        cpu_read(1'b0, 1'b0);
        check("aw19_prg10_8000", 32'(prg_a19), 32'h10);

        // RST wins over a simultaneous write
        write_cyc(1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycle();
        rst = 1'b1;
        write_cyc(1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        check("rst_prio_count", 32'(dut.u_serial.count_q), 32'd0);
        check("rst_prio_ctrl", 32'(dut.ctrl_q), 32'h0C);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
